feature_skew_feeder: RTL

FEATURE_SKEW_FEEDER -- requirements
Module: feature_skew_feeder

---
 rtl/feature_skew_feeder_pkg.sv | 14 +
 rtl/feature_skew_feeder_skew_delay_line.sv | 31 +++
 rtl/feature_skew_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/feature_skew_feeder_pkg.sv
// Shared definitions for the feature skew feeder and the systolic array top.
package feature_skew_feeder_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned ROW   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/feature_skew_feeder_skew_delay_line.sv
// One skew lane: a depth-stage shift register that advances only when enabled.
// clr_in synchronously empties every stage.
module skew_delay_line #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             clr_in,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage_q [depth];

    // Shift chain: stage 0 takes d, each later stage takes its predecessor.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < depth; i++) stage_q[i] <= '0;
        end else if (clr_in) begin
            for (int unsigned i = 0; i < depth; i++) stage_q[i] <= '0;
        end else if (en) begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[depth-1];

endmodule

// File: rtl/feature_skew_feeder.sv
// Feeds im2col columns into a systolic array with a per-lane diagonal skew:
// lane j is delayed by j steps, then the array is drained with zeros.
module feature_skew_feeder
    import feature_skew_feeder_pkg::*;
#(
    parameter int unsigned width = WIDTH,
    parameter int unsigned row   = ROW
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [4:0]       weight_dim,
    input  logic [9:0]       num_pixels,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_vec      [row],
    output logic [width-1:0] feature_out [row],
    output logic             feed_valid,
    output logic             busy,
    output logic             feed_done,
    output logic             cfg_err
);

    feeder_state_e state_q, state_d;
    logic [4:0]    wd_q, wd_d;
    logic [4:0]    drain_q, drain_d;
    logic [9:0]    np_q, np_d;
    logic [9:0]    pix_q, pix_d;
    logic          cfg_err_q, cfg_err_d;
    logic          feed_valid_q;
    logic          accept;
    logic          step;
    logic [row-1:0] lane_act;

    // Next-state logic: job sequencing, pixel and drain counting.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        np_d      = np_q;
        pix_d     = pix_q;
        drain_d   = drain_q;
        cfg_err_d = cfg_err_q;
        accept    = in_valid && (state_q == FEED);
        step      = accept || (state_q == DRAIN);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (weight_dim == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        wd_d    = weight_dim;
                        np_d    = num_pixels;
                        state_d = (num_pixels == '0) ? DONE : FEED;
                    end
                end
            end
            FEED: begin
                if (accept) begin
                    pix_d = pix_q + 10'd1;
                    if (pix_d == np_q) begin
                        if (wd_q == 5'd1) begin
                            state_d = DONE;
                        end else begin
                            state_d = DRAIN;
                            drain_d = wd_q - 5'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - 5'd1;
                if (drain_q == 5'd1) state_d = DONE;
            end
            DONE: begin
                pix_d   = '0;
                drain_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            np_q         <= '0;
            pix_q        <= '0;
            drain_q      <= '0;
            cfg_err_q    <= 1'b0;
            feed_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            np_q         <= np_d;
            pix_q        <= pix_d;
            drain_q      <= drain_d;
            cfg_err_q    <= cfg_err_d;
            feed_valid_q <= step;
        end
    end

    // Only lanes below the latched tap count take data, and only while feeding;
    // everything else shifts in zero (this also produces the drain zeros).
    always_comb begin
        lane_act = '0;
        for (int unsigned j = 0; j < row; j++) begin
            lane_act[j] = (state_q == FEED) && (j < 32'(wd_q));
        end
    end

    for (genvar g = 0; g < row; g++) begin : g_lane
        skew_delay_line #(
            .width (width),
            .depth (g + 1)
        ) u_lane (
            .clk    (clk),
            .nrst   (nrst),
            .en     (step),
            .clr_in (state_q == DONE),
            .d      (lane_act[g] ? in_vec[g] : '0),
            .q      (feature_out[g])
        );
    end

    assign in_ready   = (state_q == FEED);
    assign busy       = (state_q != IDLE);
    assign feed_done  = (state_q == DONE);
    assign feed_valid = feed_valid_q;
    assign cfg_err    = cfg_err_q;

endmodule
